// File: rtl/rv32_types.sv
// Shared RV32 execute-stage types: ALU/MD opcodes, operand-2 source select,
// divider FSM states, decode/execute pipeline buffer structs, the canonical
// NOP encoding and its control word, plus small opcode-classification helpers.
package rv32_types;

  // addi x0, x0, 0
  localparam logic [31:0] RV_NOP = 32'h0000_0013;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
    ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND
  } alu_op_t;

  typedef enum logic [3:0] {
    MD_NONE, MD_MUL, MD_MULH, MD_MULHSU, MD_MULHU,
    MD_DIV, MD_DIVU, MD_REM, MD_REMU
  } md_op_t;

  typedef enum logic {SRC2_REG, SRC2_IMM} alu_src2_t;

  typedef enum logic [1:0] {DIV_IDLE, DIV_BUSY, DIV_DONE} div_state_t;

  typedef struct packed {
    alu_op_t   alu_op;
    md_op_t    md_op;
    alu_src2_t alu_src2;
    logic      reg_write;
    logic      mem_read;
    logic      mem_write;
  } decoded_instr_t;

  typedef struct packed {
    logic [31:0]    instr;
    logic [31:0]    pc;
    decoded_instr_t decoded_instr;
    logic [31:0]    rs1_value;
    logic [31:0]    rs2_value;
    logic [31:0]    imm;
  } decode_buffer_data_t;

  typedef struct packed {
    logic [31:0]    instr;
    logic [31:0]    pc;
    decoded_instr_t decoded_instr;
    logic [31:0]    wb_result;
    logic [31:0]    rs2_value;
  } exec_buffer_data_t;

  // Control word of the canonical NOP; writes x0, so no register write.
  function automatic decoded_instr_t create_nop_ctrl();
    decoded_instr_t c;
    c.alu_op    = ALU_ADD;
    c.md_op     = MD_NONE;
    c.alu_src2  = SRC2_IMM;
    c.reg_write = 1'b0;
    c.mem_read  = 1'b0;
    c.mem_write = 1'b0;
    return c;
  endfunction

  function automatic logic is_div_op(input md_op_t op);
    logic r;
    case (op)
      MD_DIV, MD_DIVU, MD_REM, MD_REMU: r = 1'b1;
      default:                          r = 1'b0;
    endcase
    return r;
  endfunction

  function automatic logic is_signed_div_op(input md_op_t op);
    return (op == MD_DIV) || (op == MD_REM);
  endfunction

endpackage

// File: rtl/rv32_div_unit.sv
// Iterative radix-2 restoring divider for DIV/DIVU/REM/REMU.
// Ports: clk, resetn (async active-low); start/op/a/b sampled in IDLE;
// busy while iterating; done + result while in DONE; ack returns to IDLE.
// Divide-by-zero and signed overflow skip iteration (IDLE -> DONE).
module rv32_div_unit
  import rv32_types::*;
#(
  parameter int DIV_CYCLES = 32
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        start,
  input  md_op_t      op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [31:0] result,
  input  logic        ack
);

  localparam logic [5:0] LAST_STEP = 6'(DIV_CYCLES - 1);

  div_state_t  r_state, w_next;
  logic [5:0]  r_count;
  logic [31:0] r_rem, r_quo, r_div;
  logic        r_neg_q, r_neg_r, r_is_rem;

  logic        w_signed, w_a_neg, w_b_neg, w_div_zero, w_overflow, w_special;
  logic [31:0] w_a_mag, w_b_mag;
  logic [32:0] w_shift, w_diff;
  logic [31:0] w_step_rem, w_step_quo;

  assign w_signed   = is_signed_div_op(op);
  assign w_a_neg    = w_signed & a[31];
  assign w_b_neg    = w_signed & b[31];
  assign w_a_mag    = w_a_neg ? (32'd0 - a) : a;
  assign w_b_mag    = w_b_neg ? (32'd0 - b) : b;
  assign w_div_zero = (b == 32'd0);
  assign w_overflow = w_signed & (a == 32'h8000_0000) & (b == 32'hFFFF_FFFF);
  assign w_special  = w_div_zero | w_overflow;

  // One restoring step: shift in the next dividend bit, subtract if it fits.
  // A borrow out of bit 32 means the trial subtraction went negative.
  assign w_shift    = {r_rem, r_quo[31]};
  assign w_diff     = w_shift - {1'b0, r_div};
  assign w_step_rem = w_diff[32] ? w_shift[31:0] : w_diff[31:0];
  assign w_step_quo = {r_quo[30:0], ~w_diff[32]};

  // Divider state register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= DIV_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic.
  always_comb begin
    w_next = r_state;
    case (r_state)
      DIV_IDLE: begin
        if (start) begin
          w_next = w_special ? DIV_DONE : DIV_BUSY;
        end else begin
          w_next = DIV_IDLE;
        end
      end
      DIV_BUSY: begin
        if (r_count == LAST_STEP) begin
          w_next = DIV_DONE;
        end else begin
          w_next = DIV_BUSY;
        end
      end
      DIV_DONE: begin
        if (ack) begin
          w_next = DIV_IDLE;
        end else begin
          w_next = DIV_DONE;
        end
      end
      default: w_next = DIV_IDLE;
    endcase
  end

  // Operand capture and iteration datapath. Special cases preload the final
  // quotient/remainder with sign correction disabled.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_count  <= 6'd0;
      r_rem    <= 32'd0;
      r_quo    <= 32'd0;
      r_div    <= 32'd0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_is_rem <= 1'b0;
    end else begin
      case (r_state)
        DIV_IDLE: begin
          if (start) begin
            r_is_rem <= (op == MD_REM) || (op == MD_REMU);
            r_count  <= 6'd0;
            r_div    <= w_b_mag;
            if (w_div_zero) begin
              r_quo   <= 32'hFFFF_FFFF;
              r_rem   <= a;
              r_neg_q <= 1'b0;
              r_neg_r <= 1'b0;
            end else if (w_overflow) begin
              r_quo   <= 32'h8000_0000;
              r_rem   <= 32'd0;
              r_neg_q <= 1'b0;
              r_neg_r <= 1'b0;
            end else begin
              r_quo   <= w_a_mag;
              r_rem   <= 32'd0;
              r_neg_q <= w_a_neg ^ w_b_neg;
              r_neg_r <= w_a_neg;
            end
          end
        end
        DIV_BUSY: begin
          r_rem   <= w_step_rem;
          r_quo   <= w_step_quo;
          r_count <= r_count + 6'd1;
        end
        default: begin
          r_count <= r_count;
        end
      endcase
    end
  end

  assign busy = (r_state == DIV_BUSY);
  assign done = (r_state == DIV_DONE);

  // Signs applied at DONE: quotient by operand-sign mismatch, remainder by dividend.
  always_comb begin
    if (r_is_rem) begin
      result = r_neg_r ? (32'd0 - r_rem) : r_rem;
    end else begin
      result = r_neg_q ? (32'd0 - r_quo) : r_quo;
    end
  end

endmodule

// File: rtl/rv32_exec_stage.sv
// RV32IM execute stage: inline ALU and single-cycle multiplier, iterative
// divider sub-module, registered exec_data pipeline buffer.
// Ports: clk, resetn (async active-low), decode_data (from decode buffer),
// exec_data (registered, to memory stage), stall_in (memory-stage stall),
// stall (this stage cannot accept decode_data this cycle).
module rv32_exec_stage
  import rv32_types::*;
#(
  parameter int DIV_CYCLES = 32
) (
  input  logic                clk,
  input  logic                resetn,
  input  decode_buffer_data_t decode_data,
  output exec_buffer_data_t   exec_data,
  input  logic                stall_in,
  output logic                stall
);

  decoded_instr_t w_ctrl;
  logic [31:0]    w_op1, w_op2, w_alu, w_result, w_div_result;
  logic [32:0]    w_mul_a, w_mul_b;
  logic [63:0]    w_prod;
  logic           w_is_div, w_div_busy, w_div_done, w_div_ack, w_stall;

  assign w_ctrl   = decode_data.decoded_instr;
  assign w_op1    = decode_data.rs1_value;
  assign w_op2    = (w_ctrl.alu_src2 == SRC2_IMM) ? decode_data.imm : decode_data.rs2_value;
  assign w_is_div = is_div_op(w_ctrl.md_op);

  // ALU.
  always_comb begin
    w_alu = 32'd0;
    case (w_ctrl.alu_op)
      ALU_ADD:  w_alu = w_op1 + w_op2;
      ALU_SUB:  w_alu = w_op1 - w_op2;
      ALU_SLL:  w_alu = w_op1 << w_op2[4:0];
      ALU_SLT:  w_alu = {31'd0, $signed(w_op1) < $signed(w_op2)};
      ALU_SLTU: w_alu = {31'd0, w_op1 < w_op2};
      ALU_XOR:  w_alu = w_op1 ^ w_op2;
      ALU_SRL:  w_alu = w_op1 >> w_op2[4:0];
      ALU_SRA:  w_alu = $signed(w_op1) >>> w_op2[4:0];
      ALU_OR:   w_alu = w_op1 | w_op2;
      ALU_AND:  w_alu = w_op1 & w_op2;
      default:  w_alu = 32'd0;
    endcase
  end

  // 33x33 signed product: the extra top bit is the operand's sign for signed
  // operands and zero for unsigned ones. Both are sign-extended to 64 bits so a
  // plain 64-bit multiply yields the exact signed product bits we need.
  assign w_mul_a = {(w_ctrl.md_op != MD_MULHU) & w_op1[31], w_op1};
  assign w_mul_b = {((w_ctrl.md_op == MD_MULH) || (w_ctrl.md_op == MD_MUL)) & w_op2[31], w_op2};
  assign w_prod  = {{31{w_mul_a[32]}}, w_mul_a} * {{31{w_mul_b[32]}}, w_mul_b};

  // Result select between ALU, multiplier and divider.
  always_comb begin
    w_result = w_alu;
    case (w_ctrl.md_op)
      MD_NONE:                        w_result = w_alu;
      MD_MUL:                         w_result = w_prod[31:0];
      MD_MULH, MD_MULHSU, MD_MULHU:   w_result = w_prod[63:32];
      MD_DIV, MD_DIVU, MD_REM, MD_REMU: w_result = w_div_result;
      default:                        w_result = w_alu;
    endcase
  end

  // The result is consumed only on an edge where exec_data actually loads it.
  assign w_div_ack = w_is_div & w_div_done & ~stall_in;
  assign w_stall   = stall_in | (w_is_div & (w_div_busy | ~w_div_done));
  assign stall     = w_stall;

  rv32_div_unit #(.DIV_CYCLES(DIV_CYCLES)) u_div (
    .clk    (clk),
    .resetn (resetn),
    .start  (w_is_div),
    .op     (w_ctrl.md_op),
    .a      (w_op1),
    .b      (w_op2),
    .busy   (w_div_busy),
    .done   (w_div_done),
    .result (w_div_result),
    .ack    (w_div_ack)
  );

  // Execute pipeline register: hold on downstream stall, bubble while a
  // divide is pending, otherwise capture the computed result.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      exec_data.instr         <= RV_NOP;
      exec_data.pc            <= 32'd0;
      exec_data.decoded_instr <= create_nop_ctrl();
      exec_data.wb_result     <= 32'd0;
      exec_data.rs2_value     <= 32'd0;
    end else if (stall_in) begin
      exec_data <= exec_data;
    end else if (w_stall) begin
      exec_data.instr         <= RV_NOP;
      exec_data.pc            <= 32'd0;
      exec_data.decoded_instr <= create_nop_ctrl();
      exec_data.wb_result     <= 32'd0;
      exec_data.rs2_value     <= 32'd0;
    end else begin
      exec_data.instr         <= decode_data.instr;
      exec_data.pc            <= decode_data.pc;
      exec_data.decoded_instr <= w_ctrl;
      exec_data.wb_result     <= w_result;
      exec_data.rs2_value     <= decode_data.rs2_value;
    end
  end

endmodule

// File: tb/tb_rv32_exec_stage.sv
// Directed bench for rv32_exec_stage. Inputs change on the falling clock edge;
// stall is sampled 1 time unit later and exec_data on the next falling edge.
module tb_rv32_exec_stage;
  import rv32_types::*;

  logic                clk;
  logic                resetn;
  logic                stall_in;
  logic                stall;
  decode_buffer_data_t decode_data;
  exec_buffer_data_t   exec_data;

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] pc_ctr = 32'h0000_1000;

  rv32_exec_stage #(.DIV_CYCLES(32)) dut (
    .clk         (clk),
    .resetn      (resetn),
    .decode_data (decode_data),
    .exec_data   (exec_data),
    .stall_in    (stall_in),
    .stall       (stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  function automatic decoded_instr_t mk(input alu_op_t a, input md_op_t m, input alu_src2_t s);
    decoded_instr_t c;
    c.alu_op    = a;
    c.md_op     = m;
    c.alu_src2  = s;
    c.reg_write = 1'b1;
    c.mem_read  = 1'b0;
    c.mem_write = 1'b0;
    return c;
  endfunction

  task automatic drive(input logic [31:0] ins, input decoded_instr_t c,
                       input logic [31:0] a, input logic [31:0] b, input logic [31:0] imm);
    pc_ctr = pc_ctr + 32'd4;
    decode_data.instr         = ins;
    decode_data.pc            = pc_ctr;
    decode_data.decoded_instr = c;
    decode_data.rs1_value     = a;
    decode_data.rs2_value     = b;
    decode_data.imm           = imm;
  endtask

  task automatic drive_nop();
    decode_data.instr         = RV_NOP;
    decode_data.pc            = 32'd0;
    decode_data.decoded_instr = create_nop_ctrl();
    decode_data.rs1_value     = 32'd0;
    decode_data.rs2_value     = 32'd0;
    decode_data.imm           = 32'd0;
  endtask

  // Single-cycle op: called at a falling edge, returns at a falling edge.
  task automatic run_op(input string tag, input logic [31:0] ins, input decoded_instr_t c,
                        input logic [31:0] a, input logic [31:0] b, input logic [31:0] imm,
                        input logic [31:0] exp);
    logic [31:0] pc_exp;
    drive(ins, c, a, b, imm);
    pc_exp = pc_ctr;
    #1 check({tag, "_stall"}, {31'd0, stall}, 32'd0);
    @(negedge clk);
    check({tag, "_wb"}, exec_data.wb_result, exp);
    check({tag, "_instr"}, exec_data.instr, ins);
    check({tag, "_pc"}, exec_data.pc, pc_exp);
    check({tag, "_rs2"}, exec_data.rs2_value, b);
    drive_nop();
  endtask

  // Divide: held on decode_data until its result shows up in exec_data.
  task automatic run_div(input string tag, input logic [31:0] ins, input md_op_t m,
                         input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp,
                         input int exp_stall);
    int n_stall = 0;
    int n_bub   = 0;
    logic got   = 1'b0;
    logic [31:0] res = 32'd0;
    drive(ins, mk(ALU_ADD, m, SRC2_REG), a, b, 32'd0);
    for (int cyc = 0; cyc < 80 && !got; cyc++) begin
      #1 if (stall) n_stall++;
      @(negedge clk);
      if (exec_data.instr === ins) begin
        got = 1'b1;
        res = exec_data.wb_result;
      end else if (exec_data.instr === RV_NOP) begin
        n_bub++;
      end
    end
    drive_nop();
    check({tag, "_done"}, {31'd0, got}, 32'd1);
    check({tag, "_wb"}, res, exp);
    check({tag, "_stall_cycles"}, 32'(n_stall), 32'(exp_stall));
    check({tag, "_bubbles"}, 32'(n_bub), 32'(exp_stall));
    @(negedge clk);
    check({tag, "_no_dup"}, exec_data.instr, RV_NOP);
  endtask

  initial begin
    int n_chg;
    int n_low;
    exec_buffer_data_t snap;

    resetn   = 1'b0;
    stall_in = 1'b0;
    drive_nop();
    repeat (3) @(negedge clk);

    // Reset state.
    check("rst_instr", exec_data.instr, RV_NOP);
    check("rst_pc", exec_data.pc, 32'd0);
    check("rst_wb", exec_data.wb_result, 32'd0);
    check("rst_rs2", exec_data.rs2_value, 32'd0);
    check("rst_ctrl", 32'(exec_data.decoded_instr), 32'(create_nop_ctrl()));
    check("rst_stall", {31'd0, stall}, 32'd0);
    resetn = 1'b1;
    @(negedge clk);

    // ALU and multiplier.
    run_op("add_imm_wrap", 32'h0010_0A01, mk(ALU_ADD, MD_NONE, SRC2_IMM), 32'h7FFF_FFFF, 32'h1234_5678, 32'd1, 32'h8000_0000);
    run_op("sub_reg", 32'h0010_0A02, mk(ALU_SUB, MD_NONE, SRC2_REG), 32'd5, 32'd7, 32'd99, 32'hFFFF_FFFE);
    run_op("sra_low5", 32'h0010_0A03, mk(ALU_SRA, MD_NONE, SRC2_REG), 32'h8000_0000, 32'h0000_0024, 32'd0, 32'hF800_0000);
    run_op("slt_signed", 32'h0010_0A04, mk(ALU_SLT, MD_NONE, SRC2_REG), 32'hFFFF_FFFF, 32'd1, 32'd0, 32'd1);
    run_op("sltu", 32'h0010_0A05, mk(ALU_SLTU, MD_NONE, SRC2_REG), 32'hFFFF_FFFF, 32'd1, 32'd0, 32'd0);
    run_op("xor_imm", 32'h0010_0A06, mk(ALU_XOR, MD_NONE, SRC2_IMM), 32'hF0F0_00FF, 32'd0, 32'h0FF0_0F0F, 32'hFF00_0FF0);
    run_op("mulh", 32'h0010_0B01, mk(ALU_ADD, MD_MULH, SRC2_REG), 32'h8000_0000, 32'h8000_0000, 32'd0, 32'h4000_0000);
    run_op("mulhu", 32'h0010_0B02, mk(ALU_ADD, MD_MULHU, SRC2_REG), 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'hFFFF_FFFE);
    run_op("mulhsu", 32'h0010_0B03, mk(ALU_ADD, MD_MULHSU, SRC2_REG), 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'hFFFF_FFFF);
    run_op("mul_low", 32'h0010_0B04, mk(ALU_ADD, MD_MUL, SRC2_REG), 32'd3, 32'hFFFF_FFFE, 32'd0, 32'hFFFF_FFFA);

    // Divider: normal, back-to-back, special cases.
    run_div("div_neg", 32'h0010_0C01, MD_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33);
    run_div("rem_neg", 32'h0010_0C02, MD_REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33);
    run_div("divu_100_7", 32'h0010_0C03, MD_DIVU, 32'd100, 32'd7, 32'd14, 33);
    run_div("divu_by0", 32'h0010_0C04, MD_DIVU, 32'd5, 32'd0, 32'hFFFF_FFFF, 1);
    run_div("remu_by0", 32'h0010_0C05, MD_REMU, 32'd5, 32'd0, 32'd5, 1);
    run_div("rem_ovf", 32'h0010_0C06, MD_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1);
    run_div("div_ovf", 32'h0010_0C07, MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);

    // Downstream stall held across a whole divide.
    run_op("pre_stall_add", 32'h0010_0D01, mk(ALU_ADD, MD_NONE, SRC2_IMM), 32'd40, 32'd0, 32'd2, 32'd42);
    drive(32'h0010_0D02, mk(ALU_ADD, MD_DIV, SRC2_REG), 32'd100, 32'd7, 32'd0);
    stall_in = 1'b1;
    snap  = exec_data;
    n_chg = 0;
    n_low = 0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      #1 if (!stall) n_low++;
      @(negedge clk);
      if (exec_data !== snap) n_chg++;
    end
    check("stallin_frozen", 32'(n_chg), 32'd0);
    check("stallin_stall_high", 32'(n_low), 32'd0);
    check("stallin_held_wb", exec_data.wb_result, 32'd42);
    stall_in = 1'b0;
    #1 check("stallin_release_stall", {31'd0, stall}, 32'd0);
    @(negedge clk);
    check("stallin_result_instr", exec_data.instr, 32'h0010_0D02);
    check("stallin_result_wb", exec_data.wb_result, 32'd14);
    drive_nop();
    @(negedge clk);
    check("stallin_no_dup", exec_data.instr, RV_NOP);

    // Reset in the middle of a divide; exec_data held a real result beforehand.
    run_op("pre_rst_add", 32'h0010_0E01, mk(ALU_ADD, MD_NONE, SRC2_IMM), 32'd1, 32'd0, 32'd2, 32'd3);
    drive(32'h0010_0E02, mk(ALU_ADD, MD_DIVU, SRC2_REG), 32'd100, 32'd7, 32'd0);
    stall_in = 1'b1;
    repeat (11) @(negedge clk);
    check("midrst_before_wb", exec_data.wb_result, 32'd3);
    #2 resetn = 1'b0;
    #1 check("midrst_async_instr", exec_data.instr, RV_NOP);
    check("midrst_async_wb", exec_data.wb_result, 32'd0);
    @(negedge clk);
    resetn   = 1'b1;
    stall_in = 1'b0;
    run_div("post_rst_divu", 32'h0010_0E03, MD_DIVU, 32'd100, 32'd7, 32'd14, 33);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/rv32_exec_stage.md
RV32_EXEC_STAGE -- requirements
Module: rv32_exec_stage

Interface
REQ-001 SHALL have parameter DIV_CYCLES, default 32, iterative divider step count; legal range 32 only.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port resetn, input, 1, reset; asynchronous and active-low.
REQ-004 SHALL have port decode_data, input, decode_buffer_data_t: instr, pc, decoded_instr, rs1_value, rs2_value, imm.
REQ-005 SHALL have port exec_data, output, exec_buffer_data_t: instr, pc, decoded_instr, wb_result, rs2_value; registered.
REQ-006 SHALL have port stall_in, input, 1, downstream memory-stage stall.
REQ-007 SHALL have port stall, output, 1, asserted when this stage cannot accept decode_data this cycle.

Function
REQ-008 SHALL select operand2 = imm when decoded_instr.alu_src2 == SRC2_IMM, else rs2_value; operand1 = rs1_value.
REQ-009 SHALL compute alu_op ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND at 32 bits, wrapping; shifts use operand2[4:0].
REQ-010 SHALL compute md_op MUL, MULH, MULHSU, MULHU in one cycle from a 33x33 signed product; MUL takes low 32 bits, others high 32.
REQ-011 SHALL route md_op DIV, DIVU, REM, REMU to the divider; md_op == MD_NONE selects the ALU result.
REQ-012 SHALL return quotient 0xFFFFFFFF and remainder = dividend on divide-by-zero, with a 1-cycle latency and no iteration.
REQ-013 SHALL return quotient 0x80000000 and remainder 0 on signed overflow (0x80000000 / 0xFFFFFFFF), with a 1-cycle latency.
REQ-014 SHALL run the divider FSM as IDLE -> BUSY (DIV_CYCLES cycles, radix-2 restoring on magnitudes) -> DONE -> IDLE; special cases go IDLE -> DONE.
REQ-015 SHALL apply signs at DONE: quotient negated if operand signs differ (signed ops); remainder takes the dividend sign.
REQ-016 SHALL drive stall = stall_in OR (div instruction present AND FSM not in DONE).
REQ-017 SHALL hold exec_data when stall_in=1; the divider keeps iterating, and DONE persists until the result is loaded.
REQ-018 SHALL load a NOP bubble (instr RV_NOP, create_nop_ctrl()) into exec_data when stall_in=0 and a divide is pending; it never duplicates an instruction.
REQ-019 SHALL load the computed result into exec_data when stall_in=0 and stall=0; the FSM returns to IDLE on that edge.
REQ-020 SHALL forward instr, pc, decoded_instr and rs2_value unchanged; wb_result carries the ALU/MD result (load/store address for memory ops).
REQ-021 SHALL start a divide only from IDLE; back-to-back divides restart IDLE -> BUSY the cycle after completion.
REQ-022 SHALL give a divide a latency of DIV_CYCLES+2 cycles from decode_data valid to exec_data loaded (stall_in=0), and all other ops 1 cycle.

Reset
REQ-023 SHALL, while resetn=0, set exec_data.instr=RV_NOP, decoded_instr=create_nop_ctrl(), pc=0, wb_result=0, rs2_value=0.
REQ-024 SHALL, while resetn=0, put the FSM in IDLE and clear the step counter and partial remainder/quotient.
REQ-025 SHALL abandon any in-flight divide if reset is asserted mid-divide; nothing reaches exec_data.

Structure
REQ-026 SHALL place alu_op_t, md_op_t, alu_src2_t, the divider state enum, RV_NOP and create_nop_ctrl in the shared rv32_types package.
REQ-027 SHALL implement the divider as sub-module rv32_div_unit (start, op, a, b, busy, done, result, ack); ALU and multiplier stay inline.

Verification
REQ-028 SHALL check: ADD rs1=0x7FFFFFFF, imm=1 -> wb_result 0x80000000 one cycle later, stall never high.
REQ-029 SHALL check: MULH 0x80000000 x 0x80000000 -> 0x40000000; MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE.
REQ-030 SHALL check: DIV -7/2 -> quotient 0xFFFFFFFD; REM -> 0xFFFFFFFF; stall high 33 cycles; exactly 33 NOP bubbles, then one result.
REQ-031 SHALL check: DIVU 5/0 -> 0xFFFFFFFF and REM 0x80000000/0xFFFFFFFF -> 0, each with stall high exactly 1 cycle.
REQ-032 SHALL check: stall_in held high for 40 cycles across a DIV -> exec_data frozen, result appears once after stall_in drops, no duplicate.
REQ-033 SHALL check: resetn pulsed low at BUSY step 10 -> exec_data is NOP immediately (async); next DIV completes correctly.
